// File: rtl/tm_lif_array.sv
// tm_lif_array: time-multiplexed array of leaky integrate-and-fire neurons sharing one datapath
module tm_lif_array #(
    parameter int N_NEURONS      = 8,
    parameter int WIDTH          = 8,
    parameter int LEAK_SHIFT     = 1,
    parameter int REFRAC         = 2,
    parameter int DEFAULT_THRESH = 127,
    localparam int IW            = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     current,
    input  logic                 cfg_we,
    input  logic [IW-1:0]        cfg_addr,
    input  logic [WIDTH-1:0]     cfg_thresh,
    output logic [N_NEURONS-1:0] spike,
    output logic [WIDTH-1:0]     state_out,
    output logic [IW-1:0]        upd_idx,
    output logic                 frame_done
);
    localparam int RW = REFRAC > 0 ? $clog2(REFRAC + 1) : 1;

    logic [WIDTH-1:0] v  [N_NEURONS];
    logic [WIDTH-1:0] th [N_NEURONS];
    logic [RW-1:0]    r  [N_NEURONS];
    logic [IW-1:0]    k;
    logic [WIDTH-1:0] vk, leak, sat, nv;
    logic [WIDTH:0]   sum;
    logic             refr, fire;

    // shared datapath: leak, integrate, saturate and threshold the active neuron
    always_comb begin
        vk   = v[k];
        leak = vk - (vk >> LEAK_SHIFT);
        sum  = {1'b0, leak} + {1'b0, current};
        sat  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        refr = r[k] != '0;
        fire = !refr && sat >= th[k];
        nv   = (refr || fire) ? '0 : sat;
    end

    // slot counter, per-neuron state update and threshold programming
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v[i]  <= '0;
                r[i]  <= '0;
                th[i] <= WIDTH'(DEFAULT_THRESH);
            end
            k          <= '0;
            spike      <= '0;
            state_out  <= '0;
            upd_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            k          <= (k == IW'(N_NEURONS - 1)) ? '0 : k + IW'(1);
            v[k]       <= nv;
            r[k]       <= refr ? r[k] - RW'(1) : (fire ? RW'(REFRAC) : r[k]);
            spike[k]   <= fire;
            state_out  <= nv;
            upd_idx    <= k;
            frame_done <= k == IW'(N_NEURONS - 1);
            if (cfg_we && 32'(cfg_addr) < N_NEURONS)
                th[cfg_addr] <= cfg_thresh;
        end
    end
endmodule

// File: tb/tb_tm_lif_array.sv
// tb_tm_lif_array: directed, table-driven checks of the time-multiplexed LIF array
module tb_tm_lif_array;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] current = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_thresh = '0;
    logic [7:0] spike;
    logic [7:0] state_out;
    logic [2:0] upd_idx;
    logic       frame_done;
    int checks = 0;
    int failures = 0;

    tm_lif_array dut (
        .clk(clk), .rst_n(rst_n), .current(current), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_thresh(cfg_thresh), .spike(spike),
        .state_out(state_out), .upd_idx(upd_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cur;
        logic [7:0] exp_v;
        logic       exp_sp;
        logic [7:0] exp_vec;
    } frame_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] cur, input logic we, input logic [2:0] addr, input logic [7:0] thr);
        current = cur;
        cfg_we = we;
        cfg_addr = addr;
        cfg_thresh = thr;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(8'd0, 1'b0, 3'd0, 8'd0);
        rst_n = 1'b1;
    endtask

    frame_vec_t fv [10];

    initial begin
        fv[0] = '{8'd64,  8'd0, 1'b0, 8'h00};
        fv[0].exp_v = 8'd64;
        fv[1] = '{8'd64, 8'd96,  1'b0, 8'h00};
        fv[2] = '{8'd64, 8'd112, 1'b0, 8'h00};
        fv[3] = '{8'd64, 8'd120, 1'b0, 8'h00};
        fv[4] = '{8'd64, 8'd124, 1'b0, 8'h00};
        fv[5] = '{8'd64, 8'd126, 1'b0, 8'h00};
        fv[6] = '{8'd64, 8'd0,   1'b1, 8'hFF};
        fv[7] = '{8'd64, 8'd0,   1'b0, 8'h00};
        fv[8] = '{8'd64, 8'd0,   1'b0, 8'h00};
        fv[9] = '{8'd64, 8'd64,  1'b0, 8'h00};

        // reset held three cycles with a large current on the input
        for (int c = 0; c < 3; c++) begin
            step(8'd200, 1'b0, 3'd0, 8'd0);
            chk("rst_spike", spike, 0);
            chk("rst_state", state_out, 0);
            chk("rst_idx", upd_idx, 0);
            chk("rst_fd", frame_done, 0);
        end
        rst_n = 1'b1;

        // constant current 64: spike on 7th update, two refractory slots, then restart
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 8; i++) begin
                step(fv[f].cur, 1'b0, 3'd0, 8'd0);
                chk("c64_idx", upd_idx, i);
                chk("c64_state", state_out, fv[f].exp_v);
                chk("c64_spike", spike[i], fv[f].exp_sp);
                chk("c64_fd", frame_done, i == 7);
            end
            chk("c64_vec", spike, fv[f].exp_vec);
        end

        // saturation: th[0]=255, neuron 0 fed 200 twice
        do_reset();
        step(8'd0, 1'b0, 3'd0, 8'd0);
        step(8'd0, 1'b1, 3'd0, 8'd255);
        for (int i = 2; i < 8; i++) step(8'd0, 1'b0, 3'd0, 8'd0);
        step(8'd200, 1'b0, 3'd0, 8'd0);
        chk("sat_first_state", state_out, 200);
        chk("sat_first_spike", spike[0], 0);
        for (int i = 1; i < 8; i++) step(8'd0, 1'b0, 3'd0, 8'd0);
        step(8'd200, 1'b0, 3'd0, 8'd0);
        chk("sat_second_state", state_out, 0);
        chk("sat_second_spike", spike[0], 1);
        chk("sat_only_n0", spike, 8'h01);

        // per-neuron threshold: th[3]=10 with current 16
        do_reset();
        step(8'd16, 1'b1, 3'd3, 8'd10);
        chk("pth_n0_state", state_out, 16);
        for (int i = 1; i < 8; i++) begin
            step(8'd16, 1'b0, 3'd0, 8'd0);
            chk("pth_state", state_out, i == 3 ? 0 : 16);
        end
        chk("pth_vec_f0", spike, 8'h08);
        for (int i = 0; i < 8; i++) step(8'd16, 1'b0, 3'd0, 8'd0);
        chk("pth_vec_f1", spike, 8'h00);

        // threshold write coinciding with neuron 2's own update
        do_reset();
        step(8'd16, 1'b0, 3'd0, 8'd0);
        step(8'd16, 1'b0, 3'd0, 8'd0);
        step(8'd16, 1'b1, 3'd2, 8'd5);
        chk("sim_idx", upd_idx, 2);
        chk("sim_old_state", state_out, 16);
        chk("sim_old_spike", spike[2], 0);
        for (int i = 3; i < 8; i++) step(8'd16, 1'b0, 3'd0, 8'd0);
        step(8'd16, 1'b0, 3'd0, 8'd0);
        step(8'd16, 1'b0, 3'd0, 8'd0);
        step(8'd16, 1'b0, 3'd0, 8'd0);
        chk("sim_new_spike", spike[2], 1);
        chk("sim_new_state", state_out, 0);

        // reset during neuron 0's refractory period after raising th[0]
        do_reset();
        step(8'd255, 1'b0, 3'd0, 8'd0);
        chk("mid_pre_spike", spike[0], 1);
        step(8'd0, 1'b1, 3'd0, 8'd200);
        for (int i = 2; i < 8; i++) step(8'd0, 1'b0, 3'd0, 8'd0);
        step(8'd0, 1'b0, 3'd0, 8'd0);
        step(8'd0, 1'b0, 3'd0, 8'd0);
        step(8'd0, 1'b0, 3'd0, 8'd0);
        do_reset();
        chk("mid_rst_spike", spike, 0);
        for (int f = 0; f < 7; f++) begin
            step(8'd64, 1'b0, 3'd0, 8'd0);
            chk("mid_idx", upd_idx, 0);
            chk("mid_state", state_out, fv[f].exp_v);
            chk("mid_spike", spike[0], fv[f].exp_sp);
            for (int i = 1; i < 8; i++) step(8'd64, 1'b0, 3'd0, 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
